// File: rtl/pc_sequencer_if.sv
// Sequencer control/status bundle: decoder, ALU flag, LUT write port
// and the program-counter / handshake outputs.
interface pc_sequencer_if #(
   parameter int PCW  = 10,
   parameter int LUTN = 16,
   parameter int CNTW = 16
);
   localparam int SW = $clog2(LUTN);

   logic            Start;
   logic            BranchEn;
   logic            BranchFlag;
   logic [SW-1:0]   TargetSel;
   logic            Halt;
   logic            LutWe;
   logic [SW-1:0]   LutAddr;
   logic [PCW-1:0]  LutData;
   logic [PCW-1:0]  ProgCtr;
   logic            Running;
   logic            Done;
   logic            BranchTaken;
   logic [CNTW-1:0] InstrCount;

   modport master (
      output Start, BranchEn, BranchFlag, TargetSel, Halt,
      output LutWe, LutAddr, LutData,
      input  ProgCtr, Running, Done, BranchTaken, InstrCount
   );

   modport slave (
      input  Start, BranchEn, BranchFlag, TargetSel, Halt,
      input  LutWe, LutAddr, LutData,
      output ProgCtr, Running, Done, BranchTaken, InstrCount
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / branch sequencer with branch-target LUT,
// retired-instruction counter and Start/Done program handshake.
module pc_sequencer #(
   parameter int PCW  = 10,
   parameter int LUTN = 16,
   parameter int CNTW = 16
) (
   input logic           Clk,
   input logic           Reset,
   pc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } state_t;

   state_t          state;
   logic [PCW-1:0]  lut [LUTN];
   logic [PCW-1:0]  pc;
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_inc;
   logic            running;
   logic            done;
   logic            take;
   logic [PCW-1:0]  target;

   assign take    = bus.BranchEn & bus.BranchFlag;
   // Read happens before the same-edge write lands, so collisions see old data
   assign target  = lut[bus.TargetSel];
   assign cnt_inc = (cnt == {CNTW{1'b1}}) ? cnt : cnt + CNTW'(1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         pc      <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         for (int i = 0; i < LUTN; i++)
            lut[i] <= '0;
      end else begin
         if (bus.LutWe)
            lut[bus.LutAddr] <= bus.LutData;
         unique case (state)
            IDLE, HALTED: begin
               if (bus.Start) begin
                  state   <= RUN;
                  pc      <= '0;
                  cnt     <= '0;
                  running <= 1'b1;
                  done    <= 1'b0;
               end
            end
            RUN: begin
               cnt <= cnt_inc;
               if (bus.Halt) begin
                  state   <= HALTED;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (take) begin
                  pc <= target;
               end else begin
                  pc <= pc + PCW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ProgCtr     = pc;
   assign bus.Running     = running;
   assign bus.Done        = done;
   assign bus.InstrCount  = cnt;
   assign bus.BranchTaken = take & ~bus.Halt & running;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle model comparison
// plus hand-computed literal checkpoints.
module tb_pc_sequencer;
   localparam int PCW  = 10;
   localparam int LUTN = 16;
   localparam int CNTW = 16;
   localparam int PMOD = 1 << PCW;
   localparam int CMAX = (1 << CNTW) - 1;

   logic clk;
   logic rst;

   pc_sequencer_if #(.PCW(PCW), .LUTN(LUTN), .CNTW(CNTW)) bus ();

   pc_sequencer #(.PCW(PCW), .LUTN(LUTN), .CNTW(CNTW)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int m_lut [LUTN];
   int m_pc;
   int m_cnt;
   bit m_run;
   bit m_done;

   task automatic chk(input string n, input longint a, input longint e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // One clock: check the combinational flag, advance the model, compare.
   task automatic tick();
      bit bt;
      int npc, ncnt, waddr, wdata;
      bit nrun, ndone, we;
      #1;
      bt = m_run && bus.BranchEn && bus.BranchFlag && !bus.Halt;
      chk("branch_taken", bus.BranchTaken, bt);
      npc = m_pc; ncnt = m_cnt; nrun = m_run; ndone = m_done;
      we = bus.LutWe; waddr = bus.LutAddr; wdata = bus.LutData;
      if (rst) begin
         npc = 0; ncnt = 0; nrun = 0; ndone = 0;
      end else if (!m_run) begin
         if (bus.Start) begin
            npc = 0; ncnt = 0; nrun = 1; ndone = 0;
         end
      end else begin
         ncnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         if (bus.Halt) begin
            nrun = 0; ndone = 1;
         end else if (bus.BranchEn && bus.BranchFlag) begin
            npc = m_lut[bus.TargetSel];
         end else begin
            npc = (m_pc + 1) % PMOD;
         end
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < LUTN; i++) m_lut[i] = 0;
      end else if (we) begin
         m_lut[waddr] = wdata;
      end
      m_pc = npc; m_cnt = ncnt; m_run = nrun; m_done = ndone;
      #1;
      chk("prog_ctr", bus.ProgCtr, m_pc);
      chk("instr_count", bus.InstrCount, m_cnt);
      chk("running", bus.Running, m_run);
      chk("done", bus.Done, m_done);
      chk("run_done_excl", bus.Running & bus.Done, 0);
   endtask

   task automatic idle_in();
      bus.Start = 0; bus.BranchEn = 0; bus.BranchFlag = 0;
      bus.TargetSel = '0; bus.Halt = 0; bus.LutWe = 0;
      bus.LutAddr = '0; bus.LutData = '0;
   endtask

   task automatic lut_wr(input int a, input int d);
      bus.LutWe = 1; bus.LutAddr = a[3:0]; bus.LutData = d[PCW-1:0];
      tick();
      bus.LutWe = 0;
   endtask

   task automatic branch(input int sel, input bit flag);
      bus.BranchEn = 1; bus.BranchFlag = flag; bus.TargetSel = sel[3:0];
      tick();
      bus.BranchEn = 0; bus.BranchFlag = 0;
   endtask

   task automatic restart();
      bus.Halt = 1; tick(); bus.Halt = 0;
      bus.Start = 1; tick(); bus.Start = 0;
   endtask

   initial begin
      for (int i = 0; i < LUTN; i++) m_lut[i] = 0;
      m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
      idle_in();
      rst = 1;
      @(negedge clk);
      tick(); tick();
      rst = 0;
      chk("lit_reset_pc", bus.ProgCtr, 0);
      chk("lit_reset_run", bus.Running, 0);

      // LUT loaded while idle; PC must not move
      lut_wr(3, 'h120);
      chk("lit_idle_pc", bus.ProgCtr, 0);

      bus.Start = 1; tick(); bus.Start = 0;
      chk("lit_start_pc", bus.ProgCtr, 0);
      repeat (5) tick();
      chk("lit_seq_pc", bus.ProgCtr, 5);
      chk("lit_seq_cnt", bus.InstrCount, 5);
      chk("lit_seq_run", bus.Running, 1);

      restart();
      repeat (2) tick();
      chk("lit_pc2", bus.ProgCtr, 2);
      branch(3, 1);
      chk("lit_taken", bus.ProgCtr, 'h120);

      restart();
      repeat (2) tick();
      branch(3, 0);
      chk("lit_untaken", bus.ProgCtr, 3);
      bus.BranchFlag = 1; tick(); bus.BranchFlag = 0;
      chk("lit_flag_ignored", bus.ProgCtr, 4);
      repeat (3) tick();
      chk("lit_pc7", bus.ProgCtr, 7);

      // Halt together with a taken branch: halt wins
      bus.Halt = 1; bus.BranchEn = 1; bus.BranchFlag = 1; bus.TargetSel = 3;
      tick();
      idle_in();
      chk("lit_halt_pc", bus.ProgCtr, 7);
      chk("lit_halt_cnt", bus.InstrCount, 8);
      chk("lit_halt_done", bus.Done, 1);
      bus.Halt = 1; bus.BranchEn = 1; bus.BranchFlag = 1;
      repeat (3) tick();
      idle_in();
      chk("lit_hold_pc", bus.ProgCtr, 7);
      chk("lit_hold_cnt", bus.InstrCount, 8);
      bus.Start = 1; tick(); bus.Start = 0;
      chk("lit_restart_cnt", bus.InstrCount, 0);
      chk("lit_restart_run", bus.Running, 1);

      lut_wr(0, 'h3FF);
      branch(0, 1);
      chk("lit_wrap_a", bus.ProgCtr, 'h3FF);
      tick();
      chk("lit_wrap_b", bus.ProgCtr, 0);
      tick();
      chk("lit_wrap_c", bus.ProgCtr, 1);

      lut_wr(5, 'h010);
      bus.LutWe = 1; bus.LutAddr = 5; bus.LutData = 'h020;
      branch(5, 1);
      bus.LutWe = 0;
      chk("lit_collide_old", bus.ProgCtr, 'h010);
      branch(5, 1);
      chk("lit_collide_new", bus.ProgCtr, 'h020);

      // Counter saturation
      repeat (CMAX + 4) tick();
      chk("lit_cnt_sat", bus.InstrCount, CMAX);

      branch(3, 1); branch(5, 1); branch(0, 1); branch(3, 1);
      chk("lit_pre_rst_pc", bus.ProgCtr, 'h120);
      rst = 1; bus.Start = 1; bus.Halt = 1; bus.LutWe = 1;
      bus.LutAddr = 7; bus.LutData = 'h155;
      tick();
      idle_in();
      rst = 0;
      chk("lit_mid_rst_pc", bus.ProgCtr, 0);
      chk("lit_mid_rst_cnt", bus.InstrCount, 0);
      chk("lit_mid_rst_run", bus.Running, 0);
      bus.Start = 1; tick(); bus.Start = 0;
      branch(3, 1);
      chk("lit_lut_cleared3", bus.ProgCtr, 0);
      branch(7, 1);
      chk("lit_lut_cleared7", bus.ProgCtr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and branch sequencer for the single-cycle core. It sits directly downstream of the ALU: each cycle it consumes the ALU's `BranchFlag` together with decoder control to choose between `PC+1` and a branch target read from an internal target lookup table (LUT). It produces the instruction-memory address, counts retired instructions, and runs the Start/Done program handshake with the testbench.

## Interface
- `PCW`, default 10: program counter width, in bits.
- `LUTN`, default 16: number of branch-target LUT entries. Must be a power of 2.
- `CNTW`, default 16: width of the retired-instruction counter.

Ports (clock and reset first):
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  reset, synchronous and active-high.
- `Start`  in  1  request to begin program execution; sampled only in IDLE or HALTED.
- `BranchEn`  in  1  decoder: the current instruction is a conditional branch.
- `BranchFlag`  in  1  ALU branch condition for the current instruction.
- `TargetSel`  in  log2(LUTN)  LUT index of the branch target.
- `Halt`  in  1  decoder: the current instruction is halt.
- `LutWe`  in  1  LUT write enable.
- `LutAddr`  in  log2(LUTN)  LUT write index.
- `LutData`  in  PCW  LUT write data (an absolute target address).
- `ProgCtr`  out  PCW  current instruction address.
- `Running`  out  1  high while in RUN.
- `Done`  out  1  high while in HALTED.
- `BranchTaken`  out  1  combinational: `BranchEn & BranchFlag & !Halt & Running`.
- `InstrCount`  out  CNTW  count of instructions retired since the last Start.

## Operation
States: IDLE, RUN, HALTED. Reset state is IDLE.

- **IDLE**
  - `ProgCtr` holds 0.
  - `Start=1` → RUN. `ProgCtr` stays 0 and `InstrCount` is set to 0 on the same edge.
- **RUN**, one instruction per cycle. Priority order:
  - `Halt=1` → HALTED. `ProgCtr` holds its value and `InstrCount` increments once (halt counts as retired).
  - else `BranchEn & BranchFlag` → `ProgCtr <= LUT[TargetSel]`, `InstrCount` increments.
  - else → `ProgCtr <= ProgCtr + 1`, `InstrCount` increments.
  - `Start` is ignored in RUN.
- **HALTED**
  - `ProgCtr` and `InstrCount` hold.
  - `Done=1`.
  - `Start=1` → RUN, with `ProgCtr <= 0` and `InstrCount <= 0` on that edge.

Arithmetic and width rules:
- `ProgCtr + 1` wraps modulo 2^PCW; `2^PCW-1` wraps to 0 with no flag.
- `InstrCount` saturates at `2^CNTW-1` and does not wrap.
- `BranchFlag` is ignored when `BranchEn=0`.

LUT behaviour:
- `LUTN` × `PCW` registers, all cleared to 0 by Reset.
- Written on the edge when `LutWe=1`. Writes are legal in any state.
- Reads are combinational. A same-cycle write to the entry being read returns the OLD value; the new value is visible from the next cycle.

## Timing
Reset, synchronous: on the first rising edge with `Reset=1`:
- state → IDLE, `ProgCtr=0`, `InstrCount=0`, all LUT entries = 0.
- Resulting outputs: `Running=0`, `Done=0`, `BranchTaken=0`.
- Reset overrides Start, Halt and LutWe in the same cycle.
- Reset in mid-RUN aborts execution immediately; there is no drain.

Latency:
- `Start` at edge N → `Running=1` after edge N, fetching address 0.
- A branch decided in cycle N → the target address appears on `ProgCtr` after edge N.
- There are no stall or bubble cycles.

Flag timing:
- `Done` rises on the edge that consumes `Halt`, and falls on the edge that consumes the next `Start`.
- `Running` and `Done` are never high together.

Simultaneous events:
- `Halt` + taken branch → halt wins.
- `LutWe` + read of the same index → old value is read.
- `Start` + `Reset` → reset wins.

## Test plan
- **Reset and sequencing:** Reset 2 cycles, then `Start`, no branches for 5 cycles → `ProgCtr` reads 0,1,2,3,4,5; `InstrCount=5`; `Running=1`, `Done=0`.
- **Taken and untaken branch:** write `LUT[3]=0x120`. At PC=2, `BranchEn=1`, `BranchFlag=1`, `TargetSel=3` → next PC=0x120 and `BranchTaken=1`. Repeat with `BranchFlag=0` → next PC=3.
- **Halt priority and restart:** at PC=7, assert `Halt=1` together with a taken branch → PC stays 7, `Done=1`, `InstrCount` frozen. Idle 3 cycles with no change. `Start` → PC=0, `InstrCount=0`, `Running=1`.
- **Wrap-around:** `LUT[0]=0x3FF` with `PCW=10`, then branch to it and run 2 non-branch cycles → PC reads 0x3FF, 0x000, 0x001.
- **LUT write/read collision:** with `LUT[5]=0x010`, in one cycle write `LUT[5]=0x020` and take a branch on index 5 → PC=0x010. The next branch on index 5 → PC=0x020.
- **Reset mid-run:** after 4 branches, assert `Reset` for 1 cycle → `ProgCtr=0`, IDLE, `InstrCount=0`, and a subsequent branch on any index goes to 0x000.
